// File: rtl/ex_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_pkg
// Shared definitions for the EX-stage hazard controller and the EX datapath.
//   REG_W      : width of a register specifier
//   FWD_*      : ForwardA/ForwardB select encodings understood by the EX muxes
//   md_state_t : state of the mult/div occupancy sequencer
// Configuration macro HAZARD_STATS_EN is consumed by the interface and top.
// ---------------------------------------------------------------------------
package ex_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_if
// Bundle of the pipeline-side signals seen by the hazard controller.
//   master modport : pipeline side (drives register ids / enables, consumes
//                    forwarding selects, stall/flush/hold and status)
//   slave modport  : the hazard controller itself
// With HAZARD_STATS_EN defined the bundle also carries stall_count and
// flush_count; without it those signals do not exist.
// ---------------------------------------------------------------------------
interface ex_hazard_ctrl_if;
    import ex_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_wr_reg;
    logic             ex_MemRead;
    logic             ex_muldiv_start;
    logic             ex_branch_taken;
    logic [REG_W-1:0] mem_wr_reg;
    logic             mem_RegWrite;
    logic [REG_W-1:0] wb_wr_reg;
    logic             wb_RegWrite;

    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_Hold;
    logic             muldiv_busy;
    logic             muldiv_done;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_count;
    logic [31:0]      flush_count;
`endif

    // Pipeline side: supplies operand/destination info, receives controls.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_rs, ex_rt, ex_wr_reg, ex_MemRead, ex_muldiv_start, ex_branch_taken,
        output mem_wr_reg, mem_RegWrite, wb_wr_reg, wb_RegWrite,
        input  ForwardA, ForwardB, PC_Write, IF_ID_Write,
        input  IF_ID_Flush, ID_EX_Flush, EX_Hold, muldiv_busy, muldiv_done
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );

    // Controller side: mirror image of the pipeline view.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_rs, ex_rt, ex_wr_reg, ex_MemRead, ex_muldiv_start, ex_branch_taken,
        input  mem_wr_reg, mem_RegWrite, wb_wr_reg, wb_RegWrite,
        output ForwardA, ForwardB, PC_Write, IF_ID_Write,
        output IF_ID_Flush, ID_EX_Flush, EX_Hold, muldiv_busy, muldiv_done
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_fwd_sel
// Forwarding select for one EX source operand.
//   i_src                        : source register of the EX instruction
//   i_memWrReg / i_memRegWrite   : EX/MEM destination and write enable
//   i_wbWrReg  / i_wbRegWrite    : MEM/WB destination and write enable
//   o_sel                        : FWD_EXMEM, FWD_WB or FWD_REG
// ---------------------------------------------------------------------------
module ex_hazard_ctrl_fwd_sel
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_memWrReg,
    input  logic             i_memRegWrite,
    input  logic [REG_W-1:0] i_wbWrReg,
    input  logic             i_wbRegWrite,
    output logic [1:0]       o_sel
);

    // The EX/MEM result is younger than the MEM/WB one, so it is tested first
    // and wins when both stages target the same register. A destination of
    // register 0 is never a real producer, which also keeps src==0 at FWD_REG.
    always_comb begin
        o_sel = FWD_REG;
        if (i_memRegWrite && (i_memWrReg != '0) && (i_memWrReg == i_src)) begin
            o_sel = FWD_EXMEM;
        end else if (i_wbRegWrite && (i_wbWrReg != '0) && (i_wbWrReg == i_src)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl
// EX-stage hazard and sequencing controller for the 5-stage pipeline.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : ex_hazard_ctrl_if.slave carrying ID/EX/MEM/WB register info
//                and producing ForwardA/B, PC_Write, IF_ID_Write, IF_ID_Flush,
//                ID_EX_Flush, EX_Hold, muldiv_busy, muldiv_done
// Parameter MULDIV_CYCLES (2..16): cycles a mult/div stays in EX.
// Macro HAZARD_STATS_EN adds free-running stall_count / flush_count outputs.
// Control priority: mult/div hold > taken-branch flush > load-use stall.
// All combinational outputs are forced to their idle values while reset is
// high so that an abort during a mult/div is visible immediately.
// ---------------------------------------------------------------------------
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    ex_hazard_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

    md_state_t  r_state;
    logic [3:0] r_cnt;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;
    logic       w_hold;
    logic       w_loadUse;
    logic       w_stall;
    logic       w_flush;

    ex_hazard_ctrl_fwd_sel u_fwdA (
        .i_src         (bus.ex_rs),
        .i_memWrReg    (bus.mem_wr_reg),
        .i_memRegWrite (bus.mem_RegWrite),
        .i_wbWrReg     (bus.wb_wr_reg),
        .i_wbRegWrite  (bus.wb_RegWrite),
        .o_sel         (w_fwdA)
    );

    ex_hazard_ctrl_fwd_sel u_fwdB (
        .i_src         (bus.ex_rt),
        .i_memWrReg    (bus.mem_wr_reg),
        .i_memRegWrite (bus.mem_RegWrite),
        .i_wbWrReg     (bus.wb_wr_reg),
        .i_wbRegWrite  (bus.wb_RegWrite),
        .o_sel         (w_fwdB)
    );

    // Mult/div occupancy sequencer. The start cycle itself is spent in IDLE,
    // so the counter is loaded with MULDIV_CYCLES-1 and the cycle where it
    // reads 1 is the release (done) cycle. Start requests seen while BUSY
    // belong to the instruction already being held and are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (bus.ex_muldiv_start) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= CNT_INIT;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt > 4'd1) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= MD_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Hold covers the start cycle plus every BUSY cycle except the last one.
    assign w_hold = !reset &&
                    (((r_state == MD_IDLE) && bus.ex_muldiv_start) ||
                     ((r_state == MD_BUSY) && (r_cnt > 4'd1)));

    // A load whose destination is read by the instruction in ID.
    assign w_loadUse = bus.ex_MemRead && (bus.ex_wr_reg != '0) &&
                       ((bus.id_uses_rs && (bus.id_rs == bus.ex_wr_reg)) ||
                        (bus.id_uses_rt && (bus.id_rt == bus.ex_wr_reg)));

    // A held mult/div masks everything below it; a taken branch kills the
    // ID instruction, which makes any load-use stall for it pointless.
    assign w_flush = !reset && !w_hold && bus.ex_branch_taken;
    assign w_stall = !reset && !w_hold && !bus.ex_branch_taken && w_loadUse;

    assign bus.ForwardA    = reset ? FWD_REG : w_fwdA;
    assign bus.ForwardB    = reset ? FWD_REG : w_fwdB;
    assign bus.PC_Write    = !(w_hold || w_stall);
    assign bus.IF_ID_Write = !(w_hold || w_stall);
    assign bus.IF_ID_Flush = w_flush;
    assign bus.ID_EX_Flush = w_flush || w_stall;
    assign bus.EX_Hold     = w_hold;
    assign bus.muldiv_busy = (r_state == MD_BUSY) && (r_cnt > 4'd1);
    assign bus.muldiv_done = (r_state == MD_BUSY) && (r_cnt == 4'd1);

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCount;
    logic [31:0] r_flushCount;

    // Event counters for performance analysis; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (!bus.PC_Write) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
            if (bus.IF_ID_Flush) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign bus.stall_count = r_stallCount;
    assign bus.flush_count = r_flushCount;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_hazard_ctrl
// Drives ex_hazard_ctrl through its interface with directed scenarios and
// random traffic, comparing every output against a cycle-position reference
// model. Inputs change on the falling edge; outputs are sampled 1 time unit
// later. Define HAZARD_STATS_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

    localparam int MD_N = 4;

    typedef struct packed {
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       idUsesRs;
        logic       idUsesRt;
        logic [4:0] exRs;
        logic [4:0] exRt;
        logic [4:0] exWrReg;
        logic       exMemRead;
        logic       exStart;
        logic       branch;
        logic [4:0] memWrReg;
        logic       memRW;
        logic [4:0] wbWrReg;
        logic       wbRW;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checksTotal = 0;
    int checksPassed = 0;

    // Reference model state: which cycle (1..MD_N) of a mult/div residency
    // the EX stage is in, 0 when no mult/div occupies EX.
    int mdPos = 0;
    int unsigned mStall = 0;
    int unsigned mFlush = 0;

    ex_hazard_ctrl_if hz();

    ex_hazard_ctrl #(.MULDIV_CYCLES(MD_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checksTotal++;
        if (obs === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdModel(input logic [4:0] src, input stim_t s);
        if (s.memRW && (s.memWrReg != 5'd0) && (s.memWrReg == src)) return 2'b10;
        if (s.wbRW && (s.wbWrReg != 5'd0) && (s.wbWrReg == src)) return 2'b01;
        return 2'b00;
    endfunction

    // One pipeline cycle: drive inputs, check every output against the model,
    // then advance the model across the coming rising edge.
    task automatic applyStimulus(input stim_t s, input logic rst);
        logic hold, done, busy, loadUse, stall, flush;
        logic [1:0] fa, fb;
        @(negedge clk);
        reset              = rst;
        hz.id_rs           = s.idRs;
        hz.id_rt           = s.idRt;
        hz.id_uses_rs      = s.idUsesRs;
        hz.id_uses_rt      = s.idUsesRt;
        hz.ex_rs           = s.exRs;
        hz.ex_rt           = s.exRt;
        hz.ex_wr_reg       = s.exWrReg;
        hz.ex_MemRead      = s.exMemRead;
        hz.ex_muldiv_start = s.exStart;
        hz.ex_branch_taken = s.branch;
        hz.mem_wr_reg      = s.memWrReg;
        hz.mem_RegWrite    = s.memRW;
        hz.wb_wr_reg       = s.wbWrReg;
        hz.wb_RegWrite     = s.wbRW;
        #1;
        if (rst) begin
            mdPos  = 0;
            mStall = 0;
            mFlush = 0;
        end else if (mdPos == 0 && s.exStart) begin
            mdPos = 1;
        end
        hold    = !rst && (mdPos >= 1) && (mdPos < MD_N);
        busy    = !rst && (mdPos >= 2) && (mdPos < MD_N);
        done    = !rst && (mdPos == MD_N);
        loadUse = s.exMemRead && (s.exWrReg != 5'd0) &&
                  ((s.idUsesRs && s.idRs == s.exWrReg) || (s.idUsesRt && s.idRt == s.exWrReg));
        stall   = !rst && !hold && !s.branch && loadUse;
        flush   = !rst && !hold && s.branch;
        fa      = rst ? 2'b00 : fwdModel(s.exRs, s);
        fb      = rst ? 2'b00 : fwdModel(s.exRt, s);

        checkOutput("ForwardA",    32'(hz.ForwardA),    32'(fa));
        checkOutput("ForwardB",    32'(hz.ForwardB),    32'(fb));
        checkOutput("PC_Write",    32'(hz.PC_Write),    32'(!(hold || stall)));
        checkOutput("IF_ID_Write", 32'(hz.IF_ID_Write), 32'(!(hold || stall)));
        checkOutput("IF_ID_Flush", 32'(hz.IF_ID_Flush), 32'(flush));
        checkOutput("ID_EX_Flush", 32'(hz.ID_EX_Flush), 32'(flush || stall));
        checkOutput("EX_Hold",     32'(hz.EX_Hold),     32'(hold));
        checkOutput("muldiv_busy", 32'(hz.muldiv_busy), 32'(busy));
        checkOutput("muldiv_done", 32'(hz.muldiv_done), 32'(done));
`ifdef HAZARD_STATS_EN
        checkOutput("stall_count", hz.stall_count, mStall);
        checkOutput("flush_count", hz.flush_count, mFlush);
`endif
        if (!rst) begin
            if (hold || stall) mStall++;
            if (flush) mFlush++;
            if (mdPos == MD_N) mdPos = 0;
            else if (mdPos != 0) mdPos++;
        end
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s.idRs      = 5'($urandom_range(0, 3));
        s.idRt      = 5'($urandom_range(0, 3));
        s.idUsesRs  = 1'($urandom_range(0, 1));
        s.idUsesRt  = 1'($urandom_range(0, 1));
        s.exRs      = 5'($urandom_range(0, 3));
        s.exRt      = 5'($urandom_range(0, 3));
        s.exWrReg   = 5'($urandom_range(0, 3));
        s.exMemRead = ($urandom_range(0, 2) == 0);
        s.exStart   = ($urandom_range(0, 5) == 0);
        s.branch    = ($urandom_range(0, 6) == 0);
        s.memWrReg  = 5'($urandom_range(0, 3));
        s.memRW     = 1'($urandom_range(0, 1));
        s.wbWrReg   = 5'($urandom_range(0, 3));
        s.wbRW      = 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin
        stim_t s;
        int holdCycles;
        s = '0;

        // Reset held from time 0.
        applyStimulus(s, 1'b1);
        applyStimulus(s, 1'b1);

        // Forwarding priority and register-0 exclusion.
        s.memWrReg = 5'd5; s.memRW = 1'b1; s.wbWrReg = 5'd5; s.wbRW = 1'b1; s.exRs = 5'd5;
        applyStimulus(s, 1'b0);
        checkOutput("tpFwdExMem", 32'(hz.ForwardA), 32'd2);
        s.memRW = 1'b0;
        applyStimulus(s, 1'b0);
        checkOutput("tpFwdWb", 32'(hz.ForwardA), 32'd1);
        s.memWrReg = 5'd0; s.wbWrReg = 5'd0; s.memRW = 1'b1; s.exRs = 5'd0;
        applyStimulus(s, 1'b0);
        checkOutput("tpFwdZero", 32'(hz.ForwardA), 32'd0);

        // Load-use stall lasting one cycle, and no stall when rt is unused.
        s = '0; s.exMemRead = 1'b1; s.exWrReg = 5'd8; s.idRt = 5'd8; s.idUsesRt = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("tpLoadUseStall", 32'(hz.PC_Write), 32'd0);
        applyStimulus('0, 1'b0);
        s.idUsesRt = 1'b0;
        applyStimulus(s, 1'b0);
        checkOutput("tpNoUseNoStall", 32'(hz.PC_Write), 32'd1);

        // Taken branch overrides a simultaneous load-use match.
        s.idUsesRt = 1'b1; s.branch = 1'b1;
        applyStimulus(s, 1'b0);
        checkOutput("tpBranchPc", 32'(hz.PC_Write), 32'd1);

        // Mult/div residency with a load-use match during the hold.
        holdCycles = 0;
        for (int i = 0; i < MD_N; i++) begin
            s = '0; s.exStart = 1'b1;
            if (i < MD_N - 1) begin
                s.exMemRead = 1'b1; s.exWrReg = 5'd8; s.idRt = 5'd8; s.idUsesRt = 1'b1;
            end
            applyStimulus(s, 1'b0);
            if (hz.EX_Hold) holdCycles++;
        end
        checkOutput("tpHoldCycles", 32'(holdCycles), 32'(MD_N - 1));
        applyStimulus('0, 1'b0);

        // One more load-use stall, then the counters see 5 stalls, 1 flush.
        s = '0; s.exMemRead = 1'b1; s.exWrReg = 5'd3; s.idRs = 5'd3; s.idUsesRs = 1'b1;
        applyStimulus(s, 1'b0);
        applyStimulus('0, 1'b0);
`ifdef HAZARD_STATS_EN
        checkOutput("tpStallCount", hz.stall_count, 32'd5);
        checkOutput("tpFlushCount", hz.flush_count, 32'd1);
`endif

        // Reset asserted mid-operation aborts it without a done pulse.
        s = '0; s.exStart = 1'b1;
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b1);
        checkOutput("tpResetHold", 32'(hz.EX_Hold), 32'd0);
        applyStimulus('0, 1'b0);
        checkOutput("tpResetNoDone", 32'(hz.muldiv_done), 32'd0);
        applyStimulus('0, 1'b0);

        // Back-to-back mult/div with no idle gap.
        s = '0; s.exStart = 1'b1;
        for (int i = 0; i < 2 * MD_N; i++) applyStimulus(s, 1'b0);
        applyStimulus('0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(randStim(), ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline's EX stage. It drives the ForwardA/ForwardB selects consumed by the EX datapath and detects load-use hazards, stalling IF/ID and bubbling ID/EX. It flushes younger stages on a taken branch or jump resolved in EX, and holds an instruction in EX for a fixed number of cycles while a multi-cycle mult/div occupies the ALU.

## Interface
- MULDIV_CYCLES, 4, total cycles a mult/div instruction occupies EX; legal range 2..16.
- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_wr_reg  in  5  destination register of the instruction in EX.
- ex_MemRead  in  1  EX instruction is a load.
- ex_muldiv_start  in  1  EX instruction is a mult/div.
- ex_branch_taken  in  1  taken branch or jump resolved in EX.
- mem_wr_reg, mem_RegWrite  in  5, 1  EX/MEM destination and write enable.
- wb_wr_reg, wb_RegWrite  in  5, 1  MEM/WB destination and write enable.
- ForwardA, ForwardB  out  2 each  00 = register file, 01 = WriteBackData, 10 = EX/MEM ALU result.
- PC_Write, IF_ID_Write  out  1 each  enables; 0 = hold.
- IF_ID_Flush, ID_EX_Flush  out  1 each  turn the stage register into a bubble on the next edge.
- EX_Hold  out  1  hold ID/EX, and load a bubble into EX/MEM.
- muldiv_busy, muldiv_done  out  1 each  FSM status.

## Operation
- Forwarding is combinational and evaluated independently for ex_rs → ForwardA and ex_rt → ForwardB.
  - Select 10 if mem_RegWrite, mem_wr_reg≠0 and mem_wr_reg equals the source.
  - Otherwise select 01 if wb_RegWrite, wb_wr_reg≠0 and wb_wr_reg equals the source.
  - Otherwise select 00. EX/MEM always wins over MEM/WB.
- Load-use is detected when ex_MemRead, ex_wr_reg≠0, and (id_uses_rs & id_rs==ex_wr_reg) or (id_uses_rt & id_rt==ex_wr_reg).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Lasts exactly one cycle per load.
- Taken branch: ex_branch_taken → IF_ID_Flush=1, ID_EX_Flush=1. This suppresses any load-use stall in the same cycle, and PC_Write stays 1.
- Mult/div FSM has states IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE & ex_muldiv_start: EX_Hold=1, PC_Write=0, IF_ID_Write=0. Next state BUSY, cnt←MULDIV_CYCLES-1.
  - BUSY & cnt>1: same hold outputs, cnt decrements, muldiv_busy=1.
  - BUSY & cnt==1: hold released, muldiv_done=1. Next state IDLE; the instruction leaves EX on this edge.
  - ex_muldiv_start is ignored while BUSY.
- Priority, highest first:
  - muldiv hold: masks load-use; ID_EX_Flush=0 while held.
  - branch flush.
  - load-use.
  - forwarding: always active.

## Timing
- Forwarding, load-use and flush outputs are zero-latency combinational. FSM outputs are decoded from registered state plus the start input.
- A mult/div resides in EX for exactly MULDIV_CYCLES cycles, with EX_Hold high for MULDIV_CYCLES-1 of them.
- Values while reset is high and after release:
  - ForwardA=ForwardB=00.
  - PC_Write=IF_ID_Write=1.
  - Flushes, EX_Hold, muldiv_busy and muldiv_done =0.
  - state=IDLE, cnt=0.
- Reset during BUSY aborts the operation immediately; no muldiv_done pulse.
- Register 0 never forwards and never triggers a stall.
- Back-to-back mult/div: the second start is seen in the cycle after done, returns to BUSY with no idle gap.

## Configuration
- HAZARD_STATS_EN defined: adds outputs stall_count[31:0] and flush_count[31:0], both reset to 0 and wrapping at 2^32.
  - stall_count increments on every cycle with PC_Write=0.
  - flush_count increments on every cycle with IF_ID_Flush=1.
- HAZARD_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared pipeline_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10, shared with the EX stage.
  - The muldiv state enum {MD_IDLE, MD_BUSY}.
- Sub-module fwd_sel: combinational priority comparator for one source operand, instantiated twice (rs, rt).

## Test plan
- EX/MEM rd=5 RegWrite=1, MEM/WB rd=5 RegWrite=1, ex_rs=5 → ForwardA=10; clear mem_RegWrite → ForwardA=01; set rd=0 → ForwardA=00.
- Load with ex_wr_reg=8, id_rt=8, id_uses_rt=1 → one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; with id_uses_rt=0 → no stall.
- ex_branch_taken=1 concurrent with a load-use match → IF_ID_Flush=ID_EX_Flush=1, PC_Write=1.
- MULDIV_CYCLES=4, ex_muldiv_start pulse held in EX → EX_Hold high 3 cycles, muldiv_done high in cycle 4, then IDLE; a load-use match during the hold produces no ID_EX_Flush.
- Assert reset in the second BUSY cycle → all outputs return to reset values asynchronously, state=IDLE, no muldiv_done.
- HAZARD_STATS_EN build: two load-use stalls, one branch, one 4-cycle mult → stall_count=5, flush_count=1.
